// File: rtl/regfile_pkg.sv
// Shared register-file constants: data/address widths and the named
// register indices that other pipeline stages refer to.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_wr_demux_decoder.sv
// Write-side demultiplexer decode: (en, addr) -> one-hot register enable,
// with the enable for the hardwired-zero register always held low.
module decoder_5to32
    import regfile_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic              en,
    input  logic [AW-1:0]     addr,
    output logic [2**AW-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file_wr_demux.sv
// MIPS general-purpose register file: one demultiplexed write port,
// two combinational read ports with optional write-first forwarding.
module reg_file_wr_demux #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              wr_ack,
    output logic [15:0]       wr_count
);

    import regfile_pkg::REG_ZERO;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wen;
    logic                accept;

    decoder_5to32 #(
        .AW (ADDR_W)
    ) u_decoder (
        .en     (we),
        .addr   (waddr),
        .onehot (wen)
    );

    // wen already excludes $0, so any set bit is an accepted write
    assign accept = |wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_ack   <= 1'b0;
            wr_count <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (wen[i]) begin
                    regs[i] <= wdata;
                end
            end
            wr_ack   <= accept;
            wr_count <= wr_count + 16'(accept);
        end
    end

    // Forwarding keys off the decoded enable, so a read of the register being
    // written this cycle returns wdata; suppressed in reset so reads stay zero.
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        if (BYPASS != 0 && !rst) begin
            if (wen[raddr_a]) rdata_a = wdata;
            if (wen[raddr_b]) rdata_b = wdata;
        end
        if (raddr_a == ADDR_W'(REG_ZERO)) rdata_a = '0;
        if (raddr_b == ADDR_W'(REG_ZERO)) rdata_b = '0;
    end

    assert property (@(posedge clk) disable iff (rst) !$isunknown(we));

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Self-checking bench for reg_file_wr_demux: one forwarding and one
// non-forwarding instance driven in parallel against an array model.
module tb_reg_file_wr_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
    logic        wr_ack, nb_wr_ack;
    logic [15:0] wr_count, nb_wr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m [32];
    logic [15:0] exp_cnt;
    logic        exp_ack;

    always #5 clk = ~clk;

    reg_file_wr_demux #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .wr_ack(wr_ack), .wr_count(wr_count)
    );

    reg_file_wr_demux #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b),
        .wr_ack(nb_wr_ack), .wr_count(nb_wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input bit fwd);
        if (ra == 5'd0) return 32'd0;
        if (fwd && !rst && we && waddr != 5'd0 && waddr == ra) return wdata;
        return m[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        exp_cnt = 16'd0;
        exp_ack = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    endtask

    task automatic check_reads(input string tag);
        #2;
        chk({tag, "_a_fwd"}, rdata_a,    model_read(raddr_a, 1'b1));
        chk({tag, "_b_fwd"}, rdata_b,    model_read(raddr_b, 1'b1));
        chk({tag, "_a_nb"},  nb_rdata_a, model_read(raddr_a, 1'b0));
        chk({tag, "_b_nb"},  nb_rdata_b, model_read(raddr_b, 1'b0));
    endtask

    // Advance one rising edge, apply the write rules to the model, then
    // optionally compare the registered outputs just after the edge.
    task automatic cycle(input bit do_chk, input string tag);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (we && waddr != 5'd0) begin
            m[waddr] = wdata;
            exp_ack  = 1'b1;
            exp_cnt  = exp_cnt + 16'd1;
        end else begin
            exp_ack = 1'b0;
        end
        #1;
        if (do_chk) begin
            chk({tag, "_ack"},    {31'd0, wr_ack},       {31'd0, exp_ack});
            chk({tag, "_cnt"},    {16'd0, wr_count},     {16'd0, exp_cnt});
            chk({tag, "_ack_nb"}, {31'd0, nb_wr_ack},    {31'd0, exp_ack});
            chk({tag, "_cnt_nb"}, {16'd0, nb_wr_count},  {16'd0, exp_cnt});
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd1);
        cycle(1'b1, "reset");
        check_reads("reset");
        rst = 1'b0;

        // two consecutive writes, ack high on both following cycles
        drive(1'b1, 5'd3, 32'd3, 5'd3, 5'd4);
        check_reads("wr3");
        cycle(1'b1, "wr3");
        drive(1'b1, 5'd4, 32'd4, 5'd3, 5'd4);
        check_reads("wr4");
        cycle(1'b1, "wr4");
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        check_reads("rd34");
        chk("count_two", {16'd0, wr_count}, 32'd2);
        cycle(1'b1, "idle1");

        // $0 must not be written
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check_reads("zero_wr");
        cycle(1'b1, "zero_wr");
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check_reads("zero_rd");

        // forwarding vs. stored value on a same-cycle write to r7
        drive(1'b1, 5'd7, 32'h11, 5'd1, 5'd2);
        cycle(1'b1, "r7_first");
        drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
        check_reads("bypass");
        chk("bypass_a_const", rdata_a, 32'h22);
        chk("nobypass_a_const", nb_rdata_a, 32'h11);
        cycle(1'b1, "r7_second");
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        check_reads("after_bypass");

        // decode sweep: reg[i] = i
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
            cycle(1'b0, "sweep_wr");
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(i));
            check_reads("sweep_rd");
            chk("sweep_idx", rdata_a, 32'(i));
            #1;
        end
        cycle(1'b1, "sweep_end");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) raddr_a = waddr;
            if ($urandom_range(0, 3) == 0) raddr_b = waddr;
            check_reads("rand");
            cycle(1'b1, "rand");
        end

        // asynchronous reset asserted mid-cycle
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        cycle(1'b1, "load5");
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        check_reads("pre_rst");
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_rd",  rdata_a,  32'd0);
        chk("async_rst_ack", {31'd0, wr_ack}, 32'd0);
        chk("async_rst_cnt", {16'd0, wr_count}, 32'd0);
        drive(1'b1, 5'd6, 32'h1234, 5'd6, 5'd5);
        check_reads("in_rst");
        cycle(1'b1, "rst_edge");
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd6, 5'd5);
        check_reads("post_rst");

        // counter wrap: 65536 accepted writes from zero
        for (int n = 0; n < 65535; n++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0);
            cycle(1'b0, "wrap_fill");
        end
        chk("cnt_ffff", {16'd0, wr_count}, {16'd0, exp_cnt});
        chk("cnt_ffff_const", {16'd0, wr_count}, 32'h0000_FFFF);
        drive(1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
        check_reads("wrap_last");
        cycle(1'b1, "wrap");
        chk("cnt_wrap_const", {16'd0, wr_count}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            check_reads("wrap_rd");
            #1;
        end
        cycle(1'b1, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
